// File: rtl/cpu_pkg.sv
// Shared types and opcode constants for the LEGv8 multi-cycle sequencer,
// instruction classifier and execution unit.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE = 3'd0,
        CLS_LDUR  = 3'd1,
        CLS_STUR  = 3'd2,
        CLS_CBZ   = 3'd3,
        CLS_CBNZ  = 3'd4,
        CLS_B     = 3'd5
    } iclass_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_PASS_B = 2'b01,
        ALU_RTYPE  = 2'b10
    } alu_op_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // CB-format keeps 8 opcode bits, B-format keeps 6; the rest is immediate.
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] MASK_CB = 11'b11111111000;
    localparam logic [10:0] MASK_B  = 11'b11111100000;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational map from Instruction[31:21] to an instruction class plus an
// illegal flag; shared by the sequencer, hazard and trace logic.
module opcode_classifier
    import cpu_pkg::*;
(
    input  logic [10:0] opcode_i,
    output iclass_e     iclass_o,
    output logic        illegal_o
);

    always_comb begin
        iclass_o  = CLS_RTYPE;
        illegal_o = 1'b0;
        if (opcode_i == OP_ADD || opcode_i == OP_SUB ||
            opcode_i == OP_AND || opcode_i == OP_ORR) begin
            iclass_o = CLS_RTYPE;
        end else if (opcode_i == OP_LDUR) begin
            iclass_o = CLS_LDUR;
        end else if (opcode_i == OP_STUR) begin
            iclass_o = CLS_STUR;
        end else if ((opcode_i & MASK_CB) == OP_CBZ) begin
            iclass_o = CLS_CBZ;
        end else if ((opcode_i & MASK_CB) == OP_CBNZ) begin
            iclass_o = CLS_CBNZ;
        end else if ((opcode_i & MASK_B) == OP_B) begin
            iclass_o = CLS_B;
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle LEGv8 control sequencer: FETCH=0 ifetch | DECODE=1 classify |
// EXECUTE=2 ALU/branch | MEMORY=3 data access | WRITEBACK=4 reg write | HALT=5 fault.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_ifetch,
    output logic        ir_load,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg2loc,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        fault,
    output logic [2:0]  state
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    iclass_e         class_q, class_d;
    logic            fault_q, fault_d;
    logic [CW-1:0]   wait_q, wait_d;
    iclass_e         dec_class;
    logic            dec_illegal;
    logic            timeout_hit;

    opcode_classifier u_classifier (
        .opcode_i  (opcode),
        .iclass_o  (dec_class),
        .illegal_o (dec_illegal)
    );

    // Fires on the last permitted wait cycle so the request never outlives the limit.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == TO_LAST) && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            class_q <= CLS_RTYPE;
            fault_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        fault_d = fault_q;
        wait_d  = '0;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else begin
                    class_d = dec_class;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (class_q)
                    CLS_RTYPE:          state_d = ST_WRITEBACK;
                    CLS_LDUR, CLS_STUR: state_d = ST_MEMORY;
                    default:            state_d = ST_FETCH;
                endcase
            end
            ST_MEMORY: begin
                if (mem_ready) begin
                    state_d = (class_q == CLS_LDUR) ? ST_WRITEBACK : ST_FETCH;
                end else if (timeout_hit) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            default:      state_d = ST_HALT;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_ifetch = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req    = 1'b1;
                    mem_ifetch = 1'b1;
                    ir_load    = mem_ready;
                    pc_write   = mem_ready;
                end
                ST_DECODE: begin
                    reg2loc = !dec_illegal &&
                              (dec_class == CLS_STUR || dec_class == CLS_CBZ ||
                               dec_class == CLS_CBNZ);
                end
                ST_EXECUTE: begin
                    case (class_q)
                        CLS_RTYPE: alu_op = ALU_RTYPE;
                        CLS_LDUR, CLS_STUR: alu_src = 1'b1;
                        CLS_CBZ: begin
                            alu_op   = ALU_PASS_B;
                            pc_src   = 1'b1;
                            pc_write = zero;
                        end
                        CLS_CBNZ: begin
                            alu_op   = ALU_PASS_B;
                            pc_src   = 1'b1;
                            pc_write = !zero;
                        end
                        default: begin
                            pc_src   = 1'b1;
                            pc_write = 1'b1;
                        end
                    endcase
                end
                ST_MEMORY: begin
                    mem_req = 1'b1;
                    mem_we  = (class_q == CLS_STUR);
                end
                ST_WRITEBACK: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (class_q == CLS_LDUR);
                end
                default: ;
            endcase
        end
    end

    assign fault = fault_q;
    assign state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: builds an expected per-cycle trace from the phase rules of
// each instruction class and compares the DUT outputs cycle by cycle.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_ifetch, ir_load, pc_write, pc_src;
    logic        reg2loc, alu_src, mem_to_reg, reg_write, fault;
    logic [1:0]  alu_op;
    logic [2:0]  state;

    cpu_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ifetch (mem_ifetch),
        .ir_load    (ir_load),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg2loc    (reg2loc),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .fault      (fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    wire [15:0] obs_v = {state, fault, mem_req, mem_we, mem_ifetch, ir_load, pc_write,
                         pc_src, reg2loc, alu_src, mem_to_reg, alu_op, reg_write};

    localparam logic [15:0] F_FAULT = 16'h1000, F_REQ = 16'h0800, F_WE = 16'h0400;
    localparam logic [15:0] F_IF = 16'h0200, F_IRL = 16'h0100, F_PCW = 16'h0080;
    localparam logic [15:0] F_PCS = 16'h0040, F_R2L = 16'h0020, F_ASRC = 16'h0010;
    localparam logic [15:0] F_M2R = 16'h0008, F_ALU10 = 16'h0004, F_ALU01 = 16'h0002;
    localparam logic [15:0] F_RW = 16'h0001, M_ALU = 16'h0006;
    localparam logic [15:0] M_BASE = 16'hFF81;
    localparam logic [15:0] M_STROBES = F_REQ | F_WE | F_IF | F_IRL | F_PCW | F_RW;
    localparam logic [10:0] OP_STUR_C = 11'b11111000000;

    typedef struct packed {
        logic [10:0] op;
        logic        zero;
        logic        rdy;
        logic [15:0] exp;
        logic [15:0] msk;
    } cyc_t;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [10:0] r11();
        return 11'($urandom);
    endfunction

    function automatic logic [15:0] st(input int s);
        return 16'(s) << 13;
    endfunction

    function automatic void push(input logic [10:0] op, input logic z, input logic r,
                                 input logic [15:0] e, input logic [15:0] m);
        q.push_back({op, z, r, e, m});
    endfunction

    // cls: 0 R-type, 1 LDUR, 2 STUR, 3 CBZ, 4 CBNZ, 5 B
    function automatic logic [10:0] op_for(input int cls);
        case (cls)
            0: case ($urandom_range(3))
                   0: return 11'b10001011000;
                   1: return 11'b11001011000;
                   2: return 11'b10001010000;
                   default: return 11'b10101010000;
               endcase
            1: return 11'b11111000010;
            2: return OP_STUR_C;
            3: return {8'b10110100, 3'($urandom)};
            4: return {8'b10110101, 3'($urandom)};
            default: return {6'b000101, 5'($urandom)};
        endcase
    endfunction

    function automatic logic is_legal(input logic [10:0] op);
        return op == 11'b10001011000 || op == 11'b11001011000 || op == 11'b10001010000 ||
               op == 11'b10101010000 || op == 11'b11111000010 || op == OP_STUR_C ||
               op[10:3] == 8'b10110100 || op[10:3] == 8'b10110101 || op[10:5] == 6'b000101;
    endfunction

    function automatic void add_fetch(input int wf);
        for (int i = 0; i < wf; i++) push(r11(), rb(), 1'b0, st(0) | F_REQ | F_IF, M_BASE);
        push(r11(), rb(), 1'b1, st(0) | F_REQ | F_IF | F_IRL | F_PCW, M_BASE | F_PCS);
    endfunction

    function automatic void add_instr(input int cls, input logic zexe, input int wf, input int wm);
        logic [10:0] op;
        logic        taken;
        logic [15:0] e, m;
        op = op_for(cls);
        add_fetch(wf);
        push(op, rb(), rb(), st(1) | ((cls >= 2 && cls <= 4) ? F_R2L : 16'h0), M_BASE | F_R2L);
        case (cls)
            0: begin e = st(2) | F_ALU10; m = M_BASE | M_ALU | F_ASRC; end
            1, 2: begin e = st(2) | F_ASRC; m = M_BASE | M_ALU | F_ASRC; end
            3, 4: begin
                taken = (cls == 3) ? zexe : !zexe;
                e = st(2) | F_ALU01 | (taken ? (F_PCW | F_PCS) : 16'h0);
                m = M_BASE | M_ALU | (taken ? F_PCS : 16'h0);
            end
            default: begin e = st(2) | F_PCW | F_PCS; m = M_BASE | F_PCS; end
        endcase
        push(r11(), zexe, rb(), e, m);
        if (cls == 1 || cls == 2) begin
            e = st(3) | F_REQ | ((cls == 2) ? F_WE : 16'h0);
            for (int i = 0; i < wm; i++) push(r11(), rb(), 1'b0, e, M_BASE);
            push(r11(), rb(), 1'b1, e, M_BASE);
        end
        if (cls <= 1) push(r11(), rb(), rb(), st(4) | F_RW | ((cls == 1) ? F_M2R : 16'h0), M_BASE | F_M2R);
    endfunction

    task automatic drive_cycle(input cyc_t c, output logic [15:0] o);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        opcode    = c.op;
        zero      = c.zero;
        mem_ready = c.rdy;
        @(negedge clk);
        o = obs_v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mem_ready = rb();
        @(posedge clk);
        #1;
        mem_ready = rb();
    endtask

    task automatic test_reset();
        logic [15:0] o;
        cyc_t c;
        @(posedge clk);
        #1;
        rst = 1'b1; mem_ready = 1'b1; opcode = r11();
        @(negedge clk);
        n_checks++;
        if ((obs_v & M_STROBES) !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_strobes: got %h want 0000", obs_v & M_STROBES);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ((obs_v & M_BASE) !== st(0)) begin
            n_errors++;
            $display("FAIL reset_state: got %h want %h", obs_v & M_BASE, st(0));
        end
        c = {r11(), rb(), 1'b0, st(0) | F_REQ | F_IF, M_BASE};
        drive_cycle(c, o);
        n_checks++;
        if ((o & c.msk) !== c.exp) begin
            n_errors++;
            $display("FAIL reset_first_req: got %h want %h", o & c.msk, c.exp);
        end
    endtask

    task automatic test_add();
        logic [15:0] o;
        cyc_t c;
        int k = 0;
        do_reset();
        add_instr(0, rb(), 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            drive_cycle(c, o);
            n_checks++;
            if ((o & c.msk) !== (c.exp & c.msk)) begin
                n_errors++;
                $display("FAIL add cyc%0d: got %h want %h mask %h", k, o & c.msk, c.exp & c.msk, c.msk);
            end
            k++;
        end
    endtask

    task automatic test_ldur_wait();
        logic [15:0] o;
        cyc_t c;
        int k = 0;
        do_reset();
        add_instr(1, rb(), 0, 3);
        add_instr(2, rb(), 2, 3);
        while (q.size() > 0) begin
            c = q.pop_front();
            drive_cycle(c, o);
            n_checks++;
            if ((o & c.msk) !== (c.exp & c.msk)) begin
                n_errors++;
                $display("FAIL ldur_wait cyc%0d: got %h want %h mask %h", k, o & c.msk, c.exp & c.msk, c.msk);
            end
            k++;
        end
    endtask

    task automatic test_branches();
        logic [15:0] o;
        cyc_t c;
        int k = 0;
        do_reset();
        add_instr(3, 1'b1, 0, 0);
        add_instr(4, 1'b1, 0, 0);
        add_instr(4, 1'b0, 1, 0);
        add_instr(3, 1'b0, 0, 0);
        add_instr(5, rb(), 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            drive_cycle(c, o);
            n_checks++;
            if ((o & c.msk) !== (c.exp & c.msk)) begin
                n_errors++;
                $display("FAIL branch cyc%0d: got %h want %h mask %h", k, o & c.msk, c.exp & c.msk, c.msk);
            end
            k++;
        end
    endtask

    task automatic test_illegal();
        logic [15:0] o;
        logic [10:0] bad;
        cyc_t c;
        int k = 0;
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            if (ph == 0) begin
                add_fetch(0);
                push(11'h7FF, rb(), rb(), st(1), M_BASE);
                for (int i = 0; i < 20; i++) push(r11(), rb(), rb(), st(5) | F_FAULT, M_BASE);
            end else begin
                bad = r11();
                while (is_legal(bad)) bad = r11();
                push(r11(), rb(), 1'b0, st(0) | F_REQ | F_IF, M_BASE);
                add_fetch(0);
                push(bad, rb(), rb(), st(1), M_BASE);
                for (int i = 0; i < 3; i++) push(r11(), rb(), rb(), st(5) | F_FAULT, M_BASE);
            end
            while (q.size() > 0) begin
                c = q.pop_front();
                drive_cycle(c, o);
                n_checks++;
                if ((o & c.msk) !== (c.exp & c.msk)) begin
                    n_errors++;
                    $display("FAIL illegal cyc%0d: got %h want %h mask %h", k, o & c.msk, c.exp & c.msk, c.msk);
                end
                k++;
            end
        end
    endtask

    task automatic test_timeout();
        logic [15:0] o;
        cyc_t c;
        int k = 0;
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            if (ph == 0) begin
                for (int i = 0; i < 4; i++) push(r11(), rb(), 1'b0, st(0) | F_REQ | F_IF, M_BASE);
            end else begin
                add_fetch(0);
                push(OP_STUR_C, rb(), rb(), st(1) | F_R2L, M_BASE | F_R2L);
                push(r11(), rb(), rb(), st(2) | F_ASRC, M_BASE | M_ALU | F_ASRC);
                for (int i = 0; i < 4; i++) push(r11(), rb(), 1'b0, st(3) | F_REQ | F_WE, M_BASE);
            end
            for (int i = 0; i < 3; i++) push(r11(), rb(), rb(), st(5) | F_FAULT, M_BASE);
            while (q.size() > 0) begin
                c = q.pop_front();
                drive_cycle(c, o);
                n_checks++;
                if ((o & c.msk) !== (c.exp & c.msk)) begin
                    n_errors++;
                    $display("FAIL timeout cyc%0d: got %h want %h mask %h", k, o & c.msk, c.exp & c.msk, c.msk);
                end
                k++;
            end
        end
    endtask

    task automatic test_reset_mid_stur();
        logic [15:0] o;
        cyc_t c;
        int k = 0;
        do_reset();
        add_fetch(1);
        push(OP_STUR_C, rb(), rb(), st(1) | F_R2L, M_BASE | F_R2L);
        push(r11(), rb(), rb(), st(2) | F_ASRC, M_BASE | M_ALU | F_ASRC);
        for (int i = 0; i < 2; i++) push(r11(), rb(), 1'b0, st(3) | F_REQ | F_WE, M_BASE);
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                @(posedge clk);
                #1;
                rst = 1'b1; mem_ready = 1'b1;
                @(negedge clk);
                n_checks++;
                if ((obs_v & M_STROBES) !== 16'h0) begin
                    n_errors++;
                    $display("FAIL mid_reset_drop: got %h want 0000", obs_v & M_STROBES);
                end
                push(r11(), rb(), 1'b0, st(0) | F_REQ | F_IF, M_BASE);
                add_instr(2, rb(), 0, 1);
            end
            while (q.size() > 0) begin
                c = q.pop_front();
                drive_cycle(c, o);
                n_checks++;
                if ((o & c.msk) !== (c.exp & c.msk)) begin
                    n_errors++;
                    $display("FAIL mid_reset cyc%0d: got %h want %h mask %h", k, o & c.msk, c.exp & c.msk, c.msk);
                end
                k++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] o;
        cyc_t c;
        int k = 0;
        do_reset();
        for (int i = 0; i < 60; i++)
            add_instr($urandom_range(5), rb(), $urandom_range(3), $urandom_range(3));
        while (q.size() > 0) begin
            c = q.pop_front();
            drive_cycle(c, o);
            n_checks++;
            if ((o & c.msk) !== (c.exp & c.msk)) begin
                n_errors++;
                $display("FAIL random cyc%0d: got %h want %h mask %h", k, o & c.msk, c.exp & c.msk, c.msk);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur_wait();
        test_branches();
        test_illegal();
        test_timeout();
        test_reset_mid_stur();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
